fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control sequencer for the in-place radix-2 DIT FFT built around the mixed-precision butterfly unit.

- Walks every stage and every butterfly of an N-point transform, one butterfly issued per cycle.
- Per issue it generates the A/B operand read addresses, the twiddle ROM index and the per-stage multiply/add precision selects.
- Delays the addresses by the butterfly pipeline latency to drive write-back.
- Sits between the data RAM, the twiddle ROM and the butterfly datapath; driven by a start/done handshake from the top-level controller.

## Interface

Parameters:
- N_LOG2, default 4: log2 of FFT size N; supported range 2..10.
- BF_LATENCY, default 2: butterfly datapath latency in cycles, read-issue to write-back; must be ≥ 1.
- PREC_MAP, default all zero, width 2*N_LOG2: bit [2s] is the multiply precision of stage s and bit [2s+1] is its add precision; 0 = FP4, 1 = FP8.

Ports:
- clk, input, 1: clock; all flops rising-edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- start, input, 1: begin a transform; sampled only in IDLE.
- hold, input, 1: stall new issues (memory not ready); does not stall the write-back delay line.
- rd_en, output, 1: butterfly issue strobe.
- rd_addr_a, output, N_LOG2: address of operand A.
- rd_addr_b, output, N_LOG2: address of operand B.
- tw_addr, output, N_LOG2-1: twiddle ROM index.
- mult_prec, output, 1: multiply precision for the issued butterfly.
- add_prec, output, 1: add precision for the issued butterfly.
- wr_en, output, 1: write-back strobe.
- wr_addr_a, output, N_LOG2: write-back address for X.
- wr_addr_b, output, N_LOG2: write-back address for Y.
- busy, output, 1: high from start acceptance through the done pulse.
- done, output, 1: one-cycle completion pulse.
- stage, output, $clog2(N_LOG2): current stage index, for debug and status.

## Operation

State machine: IDLE, RUN, DRAIN, FINISH.
- IDLE: start=1 loads stage s=0 and butterfly counter k=0, then moves to RUN. busy rises on the same edge.
- RUN: when hold=0, asserts rd_en and increments k each cycle. When hold=1, rd_en=0 and all counters freeze.
  - After issuing k=N/2-1, moves to DRAIN and loads the drain counter with BF_LATENCY.
- DRAIN: no issues. Drain counter decrements each cycle.
  - At zero, if s<N_LOG2-1: s++, k=0, return to RUN.
  - Otherwise go to FINISH.
- FINISH: done=1 for one cycle, busy drops with it, return to IDLE.

Address generation, with span=1<<s, grp=k>>s and pos=k&(span-1):
- rd_addr_a = (grp<<(s+1)) | pos
- rd_addr_b = rd_addr_a + span
- tw_addr = pos<<(N_LOG2-1-s)
- All arithmetic is unsigned and truncated to the port widths.

Precision: mult_prec = PREC_MAP[2s] and add_prec = PREC_MAP[2s+1], for the stage being issued.

Write-back:
- A BF_LATENCY-deep shift register carries {rd_en, rd_addr_a, rd_addr_b}.
- Its output drives {wr_en, wr_addr_a, wr_addr_b}.
- It shifts every cycle regardless of hold or state.

Boundary conditions:
- start while busy is ignored.
- hold during DRAIN or FINISH has no effect.
- rst_n asserted mid-transform: immediate return to IDLE, pipeline cleared, no done pulse.

## Timing

- All outputs are registered. Reset value of every output is 0.
- Address, twiddle and precision outputs are 0 whenever rd_en=0.
- Start accepted at edge 0: first rd_en in cycle 1 with addresses (0,1), tw 0.
- Stage s first issue (no hold): cycle 1 + s*(N/2+BF_LATENCY).
- Read-to-write latency: each wr_en occurs exactly BF_LATENCY cycles after its rd_en.
- Last write of a stage lands exactly 1 cycle before the first read of the next stage, so there is no RAW hazard.
- done asserts in cycle N_LOG2*(N/2+BF_LATENCY)+1 with no hold. Each hold cycle in RUN adds exactly one cycle.

## Structure

- Package fft_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN, FINISH};
  - PREC_FP4=0 and PREC_FP8=1;
  - function prec_of(map, s).
- Sub-module bf_addr_gen: combinational (s, k) → (addr_a, addr_b, tw_addr). It is instantiated once and registered in the sequencer.

## Test plan

- Reset then idle: all outputs 0; start held low for 20 cycles → no rd_en.
- N_LOG2=4, BF_LATENCY=2, single start:
  - stage 0 issues pairs (0,1),(2,3)…(14,15), tw 0;
  - stage 3 issues (0,8),(1,9)…(7,15), tw 0..7;
  - done in cycle 41.
- PREC_MAP=8'b10_01_11_00: mult/add read 0/0, 1/1, 1/0, 0/1 across stages 0..3 respectively, sampled on each rd_en.
- hold pulsed for 3 cycles mid stage 1: no issue is skipped or duplicated, wr_en trails each rd_en by 2, done in cycle 44.
- start reasserted while busy: ignored, single done. rst_n dropped mid stage 2: outputs 0 immediately, no done; a new start then runs from stage 0.
- Scoreboard for N_LOG2=2 and 6: check the full address/twiddle sequence against a reference model and check the wr_addr-to-rd_addr delay.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT stage sequencer: FSM states, precision codes and
// per-stage precision lookup.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    localparam logic PREC_FP4 = 1'b0;
    localparam logic PREC_FP8 = 1'b1;

    // Widest precision map (N_LOG2 = 10); narrower maps are zero-extended into this.
    localparam int unsigned MAP_W = 20;

    // Returns {add_prec, mult_prec} for stage s.
    function automatic logic [1:0] prec_of(input logic [MAP_W-1:0] map, input int unsigned s);
        logic [MAP_W-1:0] w_sh;
        w_sh = map >> (2 * s);
        return w_sh[1:0];
    endfunction

endpackage

// File: rtl/bf_addr_gen.sv
// Combinational radix-2 DIT butterfly address generator: maps (stage, butterfly index) to the
// two in-place operand addresses and the twiddle ROM index.
module bf_addr_gen #(
    parameter int unsigned N_LOG2 = 4
) (
    input  logic [$clog2(N_LOG2)-1:0] i_stage,
    input  logic [N_LOG2-2:0]         i_k,
    output logic [N_LOG2-1:0]         o_addr_a,
    output logic [N_LOG2-1:0]         o_addr_b,
    output logic [N_LOG2-2:0]         o_tw_addr
);

    localparam int unsigned AW = N_LOG2;
    localparam int unsigned KW = N_LOG2 - 1;
    localparam logic [KW-1:0] K_ONES = '1;
    localparam logic [AW-1:0] A_ONE  = 1;

    logic [KW-1:0] w_mask;
    logic [KW-1:0] w_grp;
    logic [KW-1:0] w_pos;

    // Mask of the low i_stage bits; the last stage (i_stage == KW) keeps all of k.
    assign w_mask    = ~(K_ONES << i_stage);
    assign w_grp     = i_k >> i_stage;
    assign w_pos     = i_k & w_mask;

    assign o_addr_a  = ((AW'(w_grp) << i_stage) << 1) | AW'(w_pos);
    assign o_addr_b  = o_addr_a + (A_ONE << i_stage);
    assign o_tw_addr = w_pos << (KW - 32'(i_stage));

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issues one radix-2 DIT butterfly per cycle across all stages of an N-point in-place FFT and
// replays each issue's addresses BF_LATENCY cycles later as the write-back strobe.
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned         N_LOG2     = 4,
    parameter int unsigned         BF_LATENCY = 2,
    parameter logic [2*N_LOG2-1:0] PREC_MAP   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      hold,
    output logic                      rd_en,
    output logic [N_LOG2-1:0]         rd_addr_a,
    output logic [N_LOG2-1:0]         rd_addr_b,
    output logic [N_LOG2-2:0]         tw_addr,
    output logic                      mult_prec,
    output logic                      add_prec,
    output logic                      wr_en,
    output logic [N_LOG2-1:0]         wr_addr_a,
    output logic [N_LOG2-1:0]         wr_addr_b,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_LOG2)-1:0] stage
);

    localparam int unsigned AW = N_LOG2;
    localparam int unsigned KW = N_LOG2 - 1;
    localparam int unsigned SW = $clog2(N_LOG2);
    localparam int unsigned CW = $clog2(BF_LATENCY + 1);
    localparam int unsigned PW = 1 + 2 * AW;
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [KW-1:0] K_LAST = '1;

    state_t        r_state, w_state_d;
    logic [SW-1:0] r_stage, w_stage_d;
    logic [KW-1:0] r_k, w_k_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          w_issue, w_busy_d, w_done_d;

    logic [AW-1:0] w_addr_a, w_addr_b;
    logic [KW-1:0] w_tw;
    logic [1:0]    w_prec;

    logic          r_rd_en, r_mult, r_add, r_busy, r_done;
    logic [AW-1:0] r_addr_a, r_addr_b;
    logic [KW-1:0] r_tw;
    logic [PW-1:0] r_pipe [BF_LATENCY];

    bf_addr_gen #(
        .N_LOG2(N_LOG2)
    ) u_addr_gen (
        .i_stage  (r_stage),
        .i_k      (r_k),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_tw_addr(w_tw)
    );

    assign w_prec = prec_of(MAP_W'(PREC_MAP), 32'(r_stage));

    always_comb begin
        w_state_d = r_state;
        w_stage_d = r_stage;
        w_k_d     = r_k;
        w_cnt_d   = r_cnt;
        w_issue   = 1'b0;
        w_busy_d  = r_busy;
        w_done_d  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy_d = start;
                if (start) begin
                    w_state_d = RUN;
                    w_stage_d = '0;
                    w_k_d     = '0;
                end
            end
            RUN: begin
                if (!hold) begin
                    w_issue = 1'b1;
                    w_k_d   = r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        w_state_d = DRAIN;
                        w_cnt_d   = CW'(BF_LATENCY);
                    end
                end
            end
            DRAIN: begin
                w_cnt_d = r_cnt - 1'b1;
                // Leave on the last drain cycle so the next stage reads right after the
                // final write of this one lands.
                if (r_cnt == CW'(1)) begin
                    if (r_stage == S_LAST) begin
                        w_state_d = FINISH;
                    end else begin
                        w_state_d = RUN;
                        w_stage_d = r_stage + 1'b1;
                        w_k_d     = '0;
                    end
                end
            end
            FINISH: begin
                w_done_d  = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_stage  <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_rd_en  <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
            r_mult   <= PREC_FP4;
            r_add    <= PREC_FP4;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_stage  <= w_stage_d;
            r_k      <= w_k_d;
            r_cnt    <= w_cnt_d;
            r_rd_en  <= w_issue;
            r_addr_a <= w_issue ? w_addr_a : '0;
            r_addr_b <= w_issue ? w_addr_b : '0;
            r_tw     <= w_issue ? w_tw : '0;
            r_mult   <= w_issue ? w_prec[0] : PREC_FP4;
            r_add    <= w_issue ? w_prec[1] : PREC_FP4;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
        end
    end

    // Fed from the registered read outputs, so the total read-to-write delay is BF_LATENCY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BF_LATENCY); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {r_rd_en, r_addr_a, r_addr_b};
            for (int i = 1; i < int'(BF_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_addr_a;
    assign rd_addr_b = r_addr_b;
    assign tw_addr   = r_tw;
    assign mult_prec = r_mult;
    assign add_prec  = r_add;
    assign busy      = r_busy;
    assign done      = r_done;
    assign stage     = r_stage;
    assign wr_en     = r_pipe[BF_LATENCY-1][PW-1];
    assign wr_addr_a = r_pipe[BF_LATENCY-1][2*AW-1:AW];
    assign wr_addr_b = r_pipe[BF_LATENCY-1][AW-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: directed table for a 16-point run plus hold, reset and
// reference-model sequence checks on 4-, 16- and 64-point instances.
module tb_fft_stage_sequencer;

    typedef struct {int cyc; int a; int b; int tw; int m; int ad; int st;} rec_t;
    typedef struct {int s; int k; int cyc; int a; int b; int tw; int m; int ad;} vec_t;

    localparam logic [7:0]  MAP4 = 8'b10_01_11_00;
    localparam logic [3:0]  MAP2 = 4'b01_10;
    localparam logic [11:0] MAP6 = 12'b11_00_10_01_00_11;

    logic clk = 1'b0;
    logic rst_n = 1'b0, hold = 1'b0;
    logic start4 = 1'b0, start2 = 1'b0, start6 = 1'b0;
    int   checks = 0, errors = 0, tcyc = 0, t0 = 0, sel = 0;
    bit   mon_on = 1'b0;
    int   done_cnt = 0, done_cyc = -1, busy_cnt = 0, idle_bad = 0;
    rec_t rq[$], wq[$], eq[$];
    vec_t tbl[14];

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    logic       d4_rd, d4_m, d4_ad, d4_we, d4_busy, d4_done;
    logic [3:0] d4_ra, d4_rb, d4_wa, d4_wb;
    logic [2:0] d4_tw;
    logic [1:0] d4_st;
    logic       d2_rd, d2_m, d2_ad, d2_we, d2_busy, d2_done;
    logic [1:0] d2_ra, d2_rb, d2_wa, d2_wb;
    logic [0:0] d2_tw, d2_st;
    logic       d6_rd, d6_m, d6_ad, d6_we, d6_busy, d6_done;
    logic [5:0] d6_ra, d6_rb, d6_wa, d6_wb;
    logic [4:0] d6_tw;
    logic [2:0] d6_st;

    fft_stage_sequencer #(.N_LOG2(4), .BF_LATENCY(2), .PREC_MAP(MAP4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .hold(hold), .rd_en(d4_rd),
        .rd_addr_a(d4_ra), .rd_addr_b(d4_rb), .tw_addr(d4_tw), .mult_prec(d4_m),
        .add_prec(d4_ad), .wr_en(d4_we), .wr_addr_a(d4_wa), .wr_addr_b(d4_wb),
        .busy(d4_busy), .done(d4_done), .stage(d4_st));

    fft_stage_sequencer #(.N_LOG2(2), .BF_LATENCY(1), .PREC_MAP(MAP2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .hold(hold), .rd_en(d2_rd),
        .rd_addr_a(d2_ra), .rd_addr_b(d2_rb), .tw_addr(d2_tw), .mult_prec(d2_m),
        .add_prec(d2_ad), .wr_en(d2_we), .wr_addr_a(d2_wa), .wr_addr_b(d2_wb),
        .busy(d2_busy), .done(d2_done), .stage(d2_st));

    fft_stage_sequencer #(.N_LOG2(6), .BF_LATENCY(3), .PREC_MAP(MAP6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .hold(hold), .rd_en(d6_rd),
        .rd_addr_a(d6_ra), .rd_addr_b(d6_rb), .tw_addr(d6_tw), .mult_prec(d6_m),
        .add_prec(d6_ad), .wr_en(d6_we), .wr_addr_a(d6_wa), .wr_addr_b(d6_wb),
        .busy(d6_busy), .done(d6_done), .stage(d6_st));

    // Observed DUT, selected by sel (0: 16-point, 1: 4-point, 2: 64-point).
    logic o_rd, o_we, o_busy, o_done;
    int   o_a, o_b, o_tw, o_m, o_ad, o_wa, o_wb, o_st;
    always_comb begin
        o_rd = d4_rd; o_we = d4_we; o_busy = d4_busy; o_done = d4_done;
        o_a = 32'(d4_ra); o_b = 32'(d4_rb); o_tw = 32'(d4_tw); o_m = 32'(d4_m);
        o_ad = 32'(d4_ad); o_wa = 32'(d4_wa); o_wb = 32'(d4_wb); o_st = 32'(d4_st);
        if (sel == 1) begin
            o_rd = d2_rd; o_we = d2_we; o_busy = d2_busy; o_done = d2_done;
            o_a = 32'(d2_ra); o_b = 32'(d2_rb); o_tw = 32'(d2_tw); o_m = 32'(d2_m);
            o_ad = 32'(d2_ad); o_wa = 32'(d2_wa); o_wb = 32'(d2_wb); o_st = 32'(d2_st);
        end else if (sel == 2) begin
            o_rd = d6_rd; o_we = d6_we; o_busy = d6_busy; o_done = d6_done;
            o_a = 32'(d6_ra); o_b = 32'(d6_rb); o_tw = 32'(d6_tw); o_m = 32'(d6_m);
            o_ad = 32'(d6_ad); o_wa = 32'(d6_wa); o_wb = 32'(d6_wb); o_st = 32'(d6_st);
        end
    end

    always @(negedge clk) begin : monitor
        int c;
        if (mon_on) begin
            c = tcyc - t0;
            if (o_rd) rq.push_back('{c, o_a, o_b, o_tw, o_m, o_ad, o_st});
            else if ((o_a | o_b | o_tw | o_m | o_ad) != 0) idle_bad++;
            if (o_we) wq.push_back('{c, o_wa, o_wb, 0, 0, 0, 0});
            if (o_done) begin done_cnt++; done_cyc = c; end
            if (o_busy) busy_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        start4 = (which == 0) ? v : 1'b0;
        start2 = (which == 1) ? v : 1'b0;
        start6 = (which == 2) ? v : 1'b0;
    endtask

    // Textbook DIT loop nest: groups of 2*half, butterflies within a group, twiddle stride.
    task automatic build_ref(input int nl, input logic [31:0] map);
        int n, half;
        eq.delete();
        n = 1 << nl;
        for (int s = 0; s < nl; s++) begin
            half = 1 << s;
            for (int j = 0; j < n; j += 2 * half)
                for (int p = 0; p < half; p++)
                    eq.push_back('{0, j + p, j + p + half, p * (n / (2 * half)),
                                   int'(map[2*s]), int'(map[2*s+1]), s});
        end
    endtask

    task automatic kick(input int which);
        @(negedge clk);
        mon_on = 1'b0;
        rq.delete(); wq.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; idle_bad = 0;
        sel = which;
        drive_start(which, 1'b1);
        @(posedge clk);
        #1;
        t0 = tcyc;
        drive_start(which, 1'b0);
        mon_on = 1'b1;
    endtask

    task automatic run_to_done(input int budget, input int hold_at, input int hold_len,
                               input bit poke);
        int c;
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            c = tcyc - t0;
            hold = (hold_len > 0) && (c >= hold_at - 1) && (c < hold_at - 1 + hold_len);
            if (poke) drive_start(sel, (c == 5) || (c == 25));
            if (done_cnt > 0 && c >= done_cyc + 3) begin
                fin = 1'b1;
                break;
            end
        end
        hold = 1'b0;
        drive_start(sel, 1'b0);
        mon_on = 1'b0;
        if (!fin) check("done_timeout", 0, 1);
    endtask

    task automatic check_run(input string tag, input int nl, input int lat,
                             input logic [31:0] map, input int hold_at, input int hold_len,
                             input int exp_done);
        int bad, tbad, wbad, half, base, n;
        build_ref(nl, map);
        half = 1 << (nl - 1);
        check({tag, "_issue_count"}, rq.size(), eq.size());
        n = (rq.size() < eq.size()) ? rq.size() : eq.size();
        bad = 0; tbad = 0; wbad = 0;
        for (int i = 0; i < n; i++) begin
            if (rq[i].a != eq[i].a || rq[i].b != eq[i].b || rq[i].tw != eq[i].tw ||
                rq[i].m != eq[i].m || rq[i].ad != eq[i].ad || rq[i].st != eq[i].st) bad++;
            base = 1 + eq[i].st * (half + lat) + (i - eq[i].st * half);
            if (hold_len > 0 && base >= hold_at) base += hold_len;
            if (rq[i].cyc != base) tbad++;
        end
        check({tag, "_issue_fields_bad"}, bad, 0);
        check({tag, "_issue_timing_bad"}, tbad, 0);
        check({tag, "_wr_count"}, wq.size(), rq.size());
        for (int i = 0; i < wq.size() && i < rq.size(); i++)
            if (wq[i].cyc != rq[i].cyc + lat || wq[i].a != rq[i].a || wq[i].b != rq[i].b)
                wbad++;
        check({tag, "_wr_trail_bad"}, wbad, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done + 1);
        check({tag, "_idle_outputs_nonzero"}, idle_bad, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(o_rd), 0);
        check({tag, "_rd_addr_a"}, o_a, 0);
        check({tag, "_rd_addr_b"}, o_b, 0);
        check({tag, "_tw_addr"}, o_tw, 0);
        check({tag, "_wr_en"}, 32'(o_we), 0);
        check({tag, "_wr_addr_b"}, o_wb, 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_stage"}, o_st, 0);
    endtask

    initial begin
        int idx;
        // {s, k} -> {issue cycle, addr_a, addr_b, tw, mult, add} for the 16-point run.
        tbl[0]  = '{0, 0, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 7, 8, 14, 15, 0, 0, 0};
        tbl[2]  = '{1, 0, 11, 0, 2, 0, 1, 1};
        tbl[3]  = '{1, 1, 12, 1, 3, 4, 1, 1};
        tbl[4]  = '{1, 2, 13, 4, 6, 0, 1, 1};
        tbl[5]  = '{1, 5, 16, 9, 11, 4, 1, 1};
        tbl[6]  = '{1, 7, 18, 13, 15, 4, 1, 1};
        tbl[7]  = '{2, 3, 24, 3, 7, 6, 1, 0};
        tbl[8]  = '{2, 4, 25, 8, 12, 0, 1, 0};
        tbl[9]  = '{2, 6, 27, 10, 14, 4, 1, 0};
        tbl[10] = '{3, 0, 31, 0, 8, 0, 0, 1};
        tbl[11] = '{3, 1, 32, 1, 9, 1, 0, 1};
        tbl[12] = '{3, 5, 36, 5, 13, 5, 0, 1};
        tbl[13] = '{3, 7, 38, 7, 15, 7, 0, 1};

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        t0 = tcyc; busy_cnt = 0; idle_bad = 0; rq.delete(); mon_on = 1'b1;
        repeat (20) @(negedge clk);
        mon_on = 1'b0;
        check("idle_no_issue", rq.size(), 0);
        check("idle_busy_cycles", busy_cnt, 0);

        // 16-point run with start re-pulsed while busy.
        kick(0);
        run_to_done(100, 0, 0, 1'b1);
        check_run("n16", 4, 2, 32'(MAP4), 0, 0, 41);
        foreach (tbl[i]) begin
            idx = tbl[i].s * 8 + tbl[i].k;
            if (idx < rq.size()) begin
                check($sformatf("tbl%0d_cycle", i), rq[idx].cyc, tbl[i].cyc);
                check($sformatf("tbl%0d_addr_a", i), rq[idx].a, tbl[i].a);
                check($sformatf("tbl%0d_addr_b", i), rq[idx].b, tbl[i].b);
                check($sformatf("tbl%0d_tw", i), rq[idx].tw, tbl[i].tw);
                check($sformatf("tbl%0d_prec", i), rq[idx].m * 2 + rq[idx].ad,
                      tbl[i].m * 2 + tbl[i].ad);
                check($sformatf("tbl%0d_stage", i), rq[idx].st, tbl[i].s);
            end else begin
                check($sformatf("tbl%0d_missing", i), rq.size(), idx + 1);
            end
        end

        // Hold for three cycles in stage 1.
        kick(0);
        run_to_done(100, 13, 3, 1'b0);
        check_run("n16_hold", 4, 2, 32'(MAP4), 13, 3, 44);

        // Reset mid stage 2, then a fresh run.
        kick(0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tcyc - t0 == 23) break;
        end
        check("mid_stage_before_reset", o_st, 2);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        mon_on = 1'b0;
        check("midreset_no_done", done_cnt, 0);
        kick(0);
        run_to_done(100, 0, 0, 1'b0);
        check_run("n16_after_reset", 4, 2, 32'(MAP4), 0, 0, 41);

        kick(1);
        run_to_done(50, 0, 0, 1'b0);
        check_run("n4", 2, 1, 32'(MAP2), 0, 0, 7);

        kick(2);
        run_to_done(400, 0, 0, 1'b0);
        check_run("n64", 6, 3, 32'(MAP6), 0, 0, 211);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
